// File: rtl/free_list_pkg.sv
// -----------------------------------------------------------------------------
// free_list_pkg -- shared system definitions for the physical-register free list
//
// The sys_defs macros (`TABLE_WRITE, `ARCHREG_NUMBER, `PREG_NUMBER) default
// here when the build does not supply them. Everything derived from them
// (lane count, list depth, tag and pointer widths, tag typedef) lives in this
// package so that the free list and its users agree on one definition.
//
// FL_DEPTH = `PREG_NUMBER - `ARCHREG_NUMBER must be a power of two: pointer
// wrap relies on plain binary overflow of a $clog2(FL_DEPTH)+1 bit counter.
// -----------------------------------------------------------------------------
`ifndef TABLE_WRITE
`define TABLE_WRITE 1
`endif
`ifndef ARCHREG_NUMBER
`define ARCHREG_NUMBER 32
`endif
`ifndef PREG_NUMBER
`define PREG_NUMBER 64
`endif

package free_list_pkg;

  localparam int W        = `TABLE_WRITE + 1;
  localparam int ARCH_N   = `ARCHREG_NUMBER;
  localparam int PREG_N   = `PREG_NUMBER;
  localparam int FL_DEPTH = PREG_N - ARCH_N;
  localparam int TAG_W    = $clog2(PREG_N);
  localparam int IDX_W    = $clog2(FL_DEPTH);
  localparam int PTR_W    = IDX_W + 1;
  localparam int CNT_W    = $clog2(W) + 1;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [IDX_W-1:0] idx_t;

  // Storage slot addressed by a wrap-bit pointer.
  function automatic idx_t idx_of(input ptr_t p);
    return p[IDX_W-1:0];
  endfunction

  // Tag held in slot i after reset: the physical registers above the
  // architectural ones start out free.
  function automatic tag_t reset_tag(input int i);
    return tag_t'(ARCH_N + i);
  endfunction

endpackage

// File: rtl/free_list_compact.sv
// -----------------------------------------------------------------------------
// free_list_compact -- W-lane popcount with exclusive prefix offsets
//
// Ports:
//   mask_i    in  W          lane enables
//   count_o   out CNT_W      number of set lanes
//   offset_o  out W x CNT_W  lane k: number of set lanes below k
//                            (lane k's slot in a lane-order compaction)
// -----------------------------------------------------------------------------
module free_list_compact
  import free_list_pkg::*;
(
  input  logic [W-1:0]       mask_i,
  output logic [CNT_W-1:0]   count_o,
  output logic [W*CNT_W-1:0] offset_o
);

  always_comb begin
    logic [CNT_W-1:0] acc;
    acc      = '0;
    offset_o = '0;
    for (int k = 0; k < W; k++) begin
      offset_o[k*CNT_W +: CNT_W] = acc;
      acc = acc + CNT_W'(mask_i[k]);
    end
    count_o = acc;
  end

endmodule

// File: rtl/free_list.sv
// -----------------------------------------------------------------------------
// free_list -- circular free list of physical register tags
//
// Offers up to W free tags per cycle to dispatch, accepts up to W freed tags
// per cycle from retire, and on a mispredict rewinds the head to the
// allocation point of the oldest unretired instruction.
//
// Ports:
//   clk             in   1          clock, all state on posedge
//   reset_n         in   1          asynchronous active-low reset
//   dispatch_req_i  in   W          per-lane tag request (thermometer)
//   alloc_tag_o     out  W x TAG_W  tag offered to each lane (lane 0 low)
//   alloc_valid_o   out  W          lane k tag valid (free_count_o > k)
//   retire_en_i     in   W          lane returns a tag
//   retire_tag_i    in   W x TAG_W  returned tag per lane (lane 0 low)
//   recover_i       in   1          squash: return speculative allocations
//   free_count_o    out  PTR_W      registered number of free tags
// Optional (macro FREE_LIST_DEBUG_EN):
//   free_list_entry_debug  out FL_DEPTH x TAG_W  raw buffer (slot 0 low)
//   head_debug_o           out PTR_W             head pointer
//   tail_debug_o           out PTR_W             tail pointer
// -----------------------------------------------------------------------------
module free_list
  import free_list_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [W-1:0]       dispatch_req_i,
  output logic [W*TAG_W-1:0] alloc_tag_o,
  output logic [W-1:0]       alloc_valid_o,
  input  logic [W-1:0]       retire_en_i,
  input  logic [W*TAG_W-1:0] retire_tag_i,
  input  logic               recover_i,
  output logic [PTR_W-1:0]   free_count_o
`ifdef FREE_LIST_DEBUG_EN
  ,
  output logic [FL_DEPTH*TAG_W-1:0] free_list_entry_debug,
  output logic [PTR_W-1:0]          head_debug_o,
  output logic [PTR_W-1:0]          tail_debug_o
`endif
);

  tag_t fl_q [FL_DEPTH];
  ptr_t head_q, tail_q, rhead_q, count_q;
  ptr_t head_d, tail_d, rhead_d, count_d;

  logic [W-1:0]       grant;
  logic [W-1:0]       pop_run;
  logic [CNT_W-1:0]   n_pop;
  logic [CNT_W-1:0]   n_push;
  logic [W*CNT_W-1:0] pop_off_unused;
  logic [W*CNT_W-1:0] push_off;
  idx_t               wr_idx [W];

  // Offer: straight from registers, so a tag written this cycle is only
  // visible next cycle and a push into an empty list cannot be popped.
  always_comb begin
    alloc_valid_o = '0;
    alloc_tag_o   = '0;
    for (int k = 0; k < W; k++) begin
      alloc_valid_o[k]              = (count_q > PTR_W'(k));
      alloc_tag_o[k*TAG_W +: TAG_W] = fl_q[idx_of(head_q + PTR_W'(k))];
    end
  end

  // Only the contiguous low run of granted lanes is served, so a gap in a
  // non-thermometer request cuts off every lane above it.
  always_comb begin
    grant      = dispatch_req_i & alloc_valid_o;
    pop_run    = '0;
    pop_run[0] = grant[0];
    for (int k = 1; k < W; k++) begin
      pop_run[k] = pop_run[k-1] & grant[k];
    end
  end

  free_list_compact u_pop_cnt (
    .mask_i   (pop_run),
    .count_o  (n_pop),
    .offset_o (pop_off_unused)
  );

  free_list_compact u_push_cmp (
    .mask_i   (retire_en_i),
    .count_o  (n_push),
    .offset_o (push_off)
  );

  // Next state. On recover the head snaps back to the retire point, which
  // already includes this cycle's retirements; this cycle's pops are dropped.
  always_comb begin
    tail_d  = tail_q + PTR_W'(n_push);
    rhead_d = rhead_q + PTR_W'(n_push);
    head_d  = recover_i ? rhead_d : (head_q + PTR_W'(n_pop));
    count_d = tail_d - head_d;
    for (int k = 0; k < W; k++) begin
      wr_idx[k] = idx_of(tail_q + PTR_W'(push_off[k*CNT_W +: CNT_W]));
    end
  end

  // Register stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        fl_q[i] <= reset_tag(i);
      end
      head_q  <= '0;
      rhead_q <= '0;
      tail_q  <= PTR_W'(FL_DEPTH);
      count_q <= PTR_W'(FL_DEPTH);
    end else begin
      for (int k = 0; k < W; k++) begin
        if (retire_en_i[k]) begin
          fl_q[wr_idx[k]] <= retire_tag_i[k*TAG_W +: TAG_W];
        end
      end
      head_q  <= head_d;
      rhead_q <= rhead_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign free_count_o = count_q;

`ifdef FREE_LIST_DEBUG_EN
  always_comb begin
    free_list_entry_debug = '0;
    for (int i = 0; i < FL_DEPTH; i++) begin
      free_list_entry_debug[i*TAG_W +: TAG_W] = fl_q[i];
    end
  end
  assign head_debug_o = head_q;
  assign tail_debug_o = tail_q;
`endif

`ifndef SYNTHESIS
  // Retire can never hand back more tags than there are slots.
  always @(posedge clk) begin
    if (reset_n) begin
      assert (!((|retire_en_i) && (count_q == PTR_W'(FL_DEPTH))))
        else $error("free_list: push while list is full");
      assert (count_d <= PTR_W'(FL_DEPTH))
        else $error("free_list: free count overflow");
    end
  end
`endif

endmodule

// File: tb/tb_free_list.sv
module tb_free_list;
  import free_list_pkg::*;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [W-1:0]       dispatch_req_i = '0;
  logic [W*TAG_W-1:0] alloc_tag_o;
  logic [W-1:0]       alloc_valid_o;
  logic [W-1:0]       retire_en_i = '0;
  logic [W*TAG_W-1:0] retire_tag_i = '0;
  logic               recover_i = 1'b0;
  logic [PTR_W-1:0]   free_count_o;
`ifdef FREE_LIST_DEBUG_EN
  logic [FL_DEPTH*TAG_W-1:0] free_list_entry_debug;
  logic [PTR_W-1:0]          head_debug_o;
  logic [PTR_W-1:0]          tail_debug_o;
`endif

  free_list dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .dispatch_req_i (dispatch_req_i),
    .alloc_tag_o    (alloc_tag_o),
    .alloc_valid_o  (alloc_valid_o),
    .retire_en_i    (retire_en_i),
    .retire_tag_i   (retire_tag_i),
    .recover_i      (recover_i),
    .free_count_o   (free_count_o)
`ifdef FREE_LIST_DEBUG_EN
    ,
    .free_list_entry_debug (free_list_entry_debug),
    .head_debug_o          (head_debug_o),
    .tail_debug_o          (tail_debug_o)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: hist is every tag ever placed in the list, in order.
  // The free tags are hist[h .. hist.size()-1]; r counts retired tags, which
  // is also where allocation stood for the oldest unretired instruction.
  int hist[$];
  int h;
  int r;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < FL_DEPTH; i++) hist.push_back(ARCH_N + i);
    h = 0;
    r = 0;
  endtask

  function automatic int m_count();
    return hist.size() - h;
  endfunction

  // Content of the storage location that hist position idx maps to: the most
  // recent tag written there (positions past the end alias FL_DEPTH back).
  function automatic int m_at(input int idx);
    int j;
    j = idx;
    while (j >= hist.size()) j -= FL_DEPTH;
    return hist[j];
  endfunction

  task automatic model_update(input logic [W-1:0] req, input logic [W-1:0] ren,
                              input logic [W*TAG_W-1:0] rt, input logic rec);
    int cnt;
    int npop;
    cnt  = m_count();
    npop = 0;
    for (int k = 0; k < W; k++)
      if (req[k] && (k < cnt) && (npop == k)) npop++;
    for (int k = 0; k < W; k++)
      if (ren[k]) begin
        hist.push_back(int'(rt[k*TAG_W +: TAG_W]));
        r++;
      end
    if (rec) h = r;
    else     h = h + npop;
  endtask

  task automatic check_state(input string tag);
    logic [W*TAG_W-1:0] etag;
    logic [W-1:0]       evld;
    int                 cnt;
    cnt = m_count();
    for (int k = 0; k < W; k++) begin
      etag[k*TAG_W +: TAG_W] = TAG_W'(m_at(h + k));
      evld[k] = (cnt > k);
    end
    chk({tag, "_count"}, 256'(free_count_o), 256'(cnt));
    chk({tag, "_valid"}, 256'(alloc_valid_o), 256'(evld));
    chk({tag, "_tags"},  256'(alloc_tag_o),   256'(etag));
`ifdef FREE_LIST_DEBUG_EN
    for (int j = 0; j < FL_DEPTH; j++) begin
      int idx;
      idx = j;
      while (idx + FL_DEPTH < hist.size()) idx += FL_DEPTH;
      chk({tag, "_dbgbuf"}, 256'(free_list_entry_debug[j*TAG_W +: TAG_W]), 256'(hist[idx]));
    end
    chk({tag, "_dbghead"}, 256'(head_debug_o), 256'(h % (2*FL_DEPTH)));
    chk({tag, "_dbgtail"}, 256'(tail_debug_o), 256'(hist.size() % (2*FL_DEPTH)));
`endif
  endtask

  // One clock: drive, compare at negedge against the pre-edge model, advance.
  task automatic step(input string tag, input logic [W-1:0] req, input logic [W-1:0] ren,
                      input logic [W*TAG_W-1:0] rt, input logic rec);
    dispatch_req_i = req;
    retire_en_i    = ren;
    retire_tag_i   = rt;
    recover_i      = rec;
    @(negedge clk);
    check_state(tag);
    model_update(req, ren, rt, rec);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    logic [W*TAG_W-1:0] etag;
    for (int k = 0; k < W; k++) etag[k*TAG_W +: TAG_W] = TAG_W'(ARCH_N + k);
    chk({tag, "_count"}, 256'(free_count_o), 256'(FL_DEPTH));
    chk({tag, "_valid"}, 256'(alloc_valid_o), 256'({W{1'b1}}));
    chk({tag, "_tags"},  256'(alloc_tag_o),   256'(etag));
  endtask

  // Called #1 after a posedge: reset lands between edges and is checked
  // before any clock can act on it.
  task automatic apply_reset(input string tag);
    #2 reset_n = 1'b0;
    #1;
    check_reset(tag);
    dispatch_req_i = '0;
    retire_en_i    = '0;
    retire_tag_i   = '0;
    recover_i      = 1'b0;
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0]       req;
    logic [W-1:0]       ren;
    logic [W*TAG_W-1:0] rt;
    logic               rec;

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    check_reset("por");
    reset_n = 1'b1;
    model_reset();

    // Idle after release
    step("r027", '0, '0, '0, 1'b0);

    // Drain all 32 tags, then one request on an empty list
    for (int i = 0; i < 16; i++) step("r028_pop", '1, '0, '0, 1'b0);
    chk("r028_empty_count", 256'(free_count_o), 256'(0));
    chk("r028_empty_valid", 256'(alloc_valid_o), 256'(0));
    step("r028_extra", '1, '0, '0, 1'b0);
    chk("r028_extra_count", 256'(free_count_o), 256'(0));

    // Push into empty list with a same-cycle request
    rt = '0;
    rt[1*TAG_W +: TAG_W] = TAG_W'(8'h21);
    step("r029_push", 2'b11, 2'b10, rt, 1'b0);
    chk("r029_count", 256'(free_count_o), 256'(1));
    chk("r029_tag0",  256'(alloc_tag_o[TAG_W-1:0]), 256'(8'h21));
    chk("r029_valid", 256'(alloc_valid_o), 256'(2'b01));
    step("r029_idle", '0, '0, '0, 1'b0);

    // Recovery: pop 4, then retire tag 5 with recover and a discarded pop
    apply_reset("r030_rst");
    step("r030_pop", '1, '0, '0, 1'b0);
    step("r030_pop", '1, '0, '0, 1'b0);
    rt = '0;
    rt[0 +: TAG_W] = TAG_W'(5);
    step("r030_rec", '1, 2'b01, rt, 1'b1);
    chk("r030_count", 256'(free_count_o), 256'(FL_DEPTH));
    chk("r030_head",  256'(alloc_tag_o), 256'({TAG_W'(34), TAG_W'(33)}));
    for (int i = 0; i < 15; i++) step("r030_drain", '1, '0, '0, 1'b0);
    chk("r030_tailtag", 256'(alloc_tag_o), 256'({TAG_W'(5), TAG_W'(63)}));
    step("r030_last", '1, '0, '0, 1'b0);

    // Randomized push/pop/recover crossing the wrap, with a reset mid-burst
    apply_reset("r031_rst0");
    for (int i = 0; i < 8; i++) step("r031_pre", '1, '0, '0, 1'b0);
    for (int i = 0; i < 90; i++) begin
      if (i == 45) apply_reset("r031_midrst");
      req = W'($urandom);
      ren = W'($urandom);
      if (m_count() + $countones(ren) > FL_DEPTH) ren = '0;
      rt = '0;
      for (int k = 0; k < W; k++)
        rt[k*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, PREG_N - 1));
      rec = ($urandom_range(0, 9) == 0);
      step("r031_rand", req, ren, rt, rec);
    end
    step("r031_final", '0, '0, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
